// File: rtl/vx_commit_arbiter_if.sv
// Commit stream bundle: one gathered commit packet per beat, valid/ready handshake.
// A beat transfers on a clock edge where valid && ready; the master holds valid and payload stable until then.
interface vx_commit_arbiter_if #(
    parameter int NUM_LANES = 4
) ();
    localparam int LID_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic                    valid;
    logic                    ready;
    logic [15:0]             uuid;
    logic [1:0]              wid;
    logic [NUM_LANES-1:0]    tmask;
    logic [31:0]             pc;
    logic                    wb;
    logic [4:0]              rd;
    logic [NUM_LANES*32-1:0] data;
    logic                    pid;
    logic                    sop;
    logic                    eop;
    logic                    is_vec;
    logic [4:0]              vd;
    logic [LID_W-1:0]        vd_lane_id;
    logic                    vd_is_last;

    modport master (
        output valid, uuid, wid, tmask, pc, wb, rd, data, pid, sop, eop,
               is_vec, vd, vd_lane_id, vd_is_last,
        input  ready
    );

    modport slave (
        input  valid, uuid, wid, tmask, pc, wb, rd, data, pid, sop, eop,
               is_vec, vd, vd_lane_id, vd_is_last,
        output ready
    );
endinterface

// File: rtl/vx_commit_arbiter.sv
// Merges per-unit commit streams into one registered commit port with round-robin
// arbitration, atomic multi-packet instructions and a retired-instruction counter.
module vx_commit_arbiter #(
    parameter int NUM_EX_UNITS = 4,
    parameter int NUM_LANES    = 4,
    parameter int CNT_W        = 32,
    parameter bit EXT_V_ENABLE = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    vx_commit_arbiter_if.slave               commit_in_if [NUM_EX_UNITS],
    vx_commit_arbiter_if.master              commit_out_if,
    output logic [$clog2(NUM_LANES+1)-1:0]   commit_tcnt,
    output logic [CNT_W-1:0]                 retired_cnt
);
    localparam int IDX_W = (NUM_EX_UNITS > 1) ? $clog2(NUM_EX_UNITS) : 1;
    localparam int TW    = $clog2(NUM_LANES + 1);
    localparam int LID_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PKT_W = 16 + 2 + NUM_LANES + 32 + 1 + 5 + NUM_LANES*32
                         + 1 + 1 + 1 + 1 + 5 + LID_W + 1;

    logic [NUM_EX_UNITS-1:0] in_valid;
    logic [NUM_EX_UNITS-1:0] in_end;
    logic [PKT_W-1:0]        in_pkt   [NUM_EX_UNITS];
    logic [NUM_LANES-1:0]    in_tmask [NUM_EX_UNITS];

    logic [IDX_W-1:0] grant;
    logic             ready_in;
    logic             accept;
    logic             sel_end;

    logic             out_valid_q, out_valid_d;
    logic [PKT_W-1:0] data_q,      data_d;
    logic [TW-1:0]    tcnt_q,      tcnt_d;
    logic             end_q,       end_d;
    logic [CNT_W-1:0] retired_q,   retired_d;
    logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic             lock_q,      lock_d;
    logic [IDX_W-1:0] lock_idx_q,  lock_idx_d;

    function automatic logic [TW-1:0] popcnt(input logic [NUM_LANES-1:0] m);
        logic [TW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            c = c + TW'(m[i]);
        end
        return c;
    endfunction

    // A vector instruction only ends on the eop beat of its last register lane.
    for (genvar g = 0; g < NUM_EX_UNITS; g++) begin : g_in
        assign in_valid[g] = commit_in_if[g].valid;
        assign in_tmask[g] = commit_in_if[g].tmask;
        assign in_end[g]   = commit_in_if[g].eop &&
                             (!EXT_V_ENABLE || !commit_in_if[g].is_vec || commit_in_if[g].vd_is_last);
        assign in_pkt[g]   = {commit_in_if[g].uuid,   commit_in_if[g].wid,
                              commit_in_if[g].tmask,  commit_in_if[g].pc,
                              commit_in_if[g].wb,     commit_in_if[g].rd,
                              commit_in_if[g].data,   commit_in_if[g].pid,
                              commit_in_if[g].sop,    commit_in_if[g].eop,
                              commit_in_if[g].is_vec, commit_in_if[g].vd,
                              commit_in_if[g].vd_lane_id, commit_in_if[g].vd_is_last};
        assign commit_in_if[g].ready = ready_in && (grant == IDX_W'(g));
    end

    // While locked the owner keeps the grant even when it has nothing to send.
    always_comb begin
        logic found;
        int   idx;
        grant = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        if (lock_q) begin
            grant = lock_idx_q;
        end else begin
            for (int i = 0; i < NUM_EX_UNITS; i++) begin
                idx = (int'(rr_ptr_q) + i) % NUM_EX_UNITS;
                if (!found && in_valid[IDX_W'(idx)]) begin
                    grant = IDX_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign ready_in = !out_valid_q || commit_out_if.ready;
    assign accept   = in_valid[grant] && ready_in;
    assign sel_end  = in_end[grant];

    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        tcnt_d      = tcnt_q;
        end_d       = end_q;
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        retired_d   = retired_q;

        if (out_valid_q && commit_out_if.ready && end_q) begin
            retired_d = retired_q + CNT_W'(1);
        end

        if (accept) begin
            out_valid_d = 1'b1;
            data_d      = in_pkt[grant];
            tcnt_d      = popcnt(in_tmask[grant]);
            end_d       = sel_end;
            if (sel_end) begin
                lock_d   = 1'b0;
                rr_ptr_d = (grant == IDX_W'(NUM_EX_UNITS - 1)) ? '0 : grant + IDX_W'(1);
            end else begin
                lock_d     = 1'b1;
                lock_idx_d = grant;
            end
        end else if (commit_out_if.ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            tcnt_q      <= '0;
            end_q       <= 1'b0;
            retired_q   <= '0;
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            tcnt_q      <= tcnt_d;
            end_q       <= end_d;
            retired_q   <= retired_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
        end
    end

    assign commit_out_if.valid = out_valid_q;
    assign {commit_out_if.uuid,   commit_out_if.wid,
            commit_out_if.tmask,  commit_out_if.pc,
            commit_out_if.wb,     commit_out_if.rd,
            commit_out_if.data,   commit_out_if.pid,
            commit_out_if.sop,    commit_out_if.eop,
            commit_out_if.is_vec, commit_out_if.vd,
            commit_out_if.vd_lane_id, commit_out_if.vd_is_last} = data_q;

    assign commit_tcnt = tcnt_q;
    assign retired_cnt = retired_q;
endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Directed bench for vx_commit_arbiter: reset, fairness, vector lock, backpressure,
// thread count and counter wrap, each with hand-computed expectations.
module tb_vx_commit_arbiter;
  localparam int N  = 4;
  localparam int L  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic out_ready;

  logic [N-1:0] in_valid;
  logic [N-1:0] in_eop;
  logic [N-1:0] in_vec;
  logic [N-1:0] in_last;
  logic [N-1:0] in_ready;
  logic [L-1:0] in_tmask [N];
  logic [3:0]   seq      [N];
  logic [15:0]  in_uuid  [N];

  logic [2:0]    commit_tcnt;
  logic [CW-1:0] retired_cnt;

  int total = 0;
  int bad = 0;
  logic [N-1:0] acc;
  logic [15:0]  fair_exp [8] = '{16'h00, 16'h10, 16'h20, 16'h30, 16'h01, 16'h11, 16'h21, 16'h31};

  vx_commit_arbiter_if #(.NUM_LANES(L)) in_if [N] ();
  vx_commit_arbiter_if #(.NUM_LANES(L)) out_if ();

  vx_commit_arbiter #(
    .NUM_EX_UNITS(N),
    .NUM_LANES(L),
    .CNT_W(CW),
    .EXT_V_ENABLE(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .commit_in_if(in_if),
    .commit_out_if(out_if),
    .commit_tcnt(commit_tcnt),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign in_uuid[g]           = {8'h00, 4'(g), seq[g]};
    assign in_if[g].valid       = in_valid[g];
    assign in_if[g].uuid        = in_uuid[g];
    assign in_if[g].wid         = 2'(g);
    assign in_if[g].tmask       = in_tmask[g];
    assign in_if[g].pc          = {16'hC0DE, in_uuid[g]};
    assign in_if[g].wb          = 1'b1;
    assign in_if[g].rd          = {1'b0, seq[g]};
    assign in_if[g].data        = {4{16'hDA7A, in_uuid[g]}};
    assign in_if[g].pid         = 1'b0;
    assign in_if[g].sop         = 1'b1;
    assign in_if[g].eop         = in_eop[g];
    assign in_if[g].is_vec      = in_vec[g];
    assign in_if[g].vd          = 5'd3;
    assign in_if[g].vd_lane_id  = '0;
    assign in_if[g].vd_is_last  = in_last[g];
    assign in_ready[g]          = in_if[g].ready;
  end
  assign out_if.ready = out_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] uuid, input logic [2:0] tc);
    chk({tag, "_valid"}, 32'(out_if.valid), 32'h1);
    chk({tag, "_uuid"},  32'(out_if.uuid),  32'(uuid));
    chk({tag, "_pc"},    out_if.pc,         {16'hC0DE, uuid});
    chk({tag, "_tcnt"},  32'(commit_tcnt),  32'(tc));
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  // Capture which sources hand over a packet on this edge, then advance them.
  task automatic edge_t();
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) seq[i] = seq[i] + 4'd1;
    end
  endtask

  task automatic step();
    half();
    edge_t();
  endtask

  initial begin
    out_ready = 1'b1;
    in_valid  = '0;
    in_eop    = '1;
    in_vec    = '0;
    in_last   = '0;
    for (int i = 0; i < N; i++) begin
      in_tmask[i] = 4'hF;
      seq[i]      = 4'd0;
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_if.valid), 32'h0);
    chk("rst_tcnt",  32'(commit_tcnt),  32'h0);
    chk("rst_ret",   32'(retired_cnt),  32'h0);

    // run a little, then reset mid-cycle with all inputs valid
    half();
    reset = 1'b0;
    in_valid = '1;
    edge_t();
    step();
    step();
    chk("pre_rst_valid", 32'(out_if.valid), 32'h1);
    chk("pre_rst_ret",   32'(retired_cnt),  32'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(out_if.valid), 32'h0);
    chk("async_tcnt",  32'(commit_tcnt),  32'h0);
    chk("async_ret",   32'(retired_cnt),  32'h0);
    for (int i = 0; i < N; i++) seq[i] = 4'd0;
    half();
    reset = 1'b0;
    #1;
    chk("first_rdy", 32'(in_ready), 32'h1);

    // round-robin fairness over 8 single-packet instructions
    edge_t();
    chk_out("rr0", fair_exp[0], 3'd4);
    for (int k = 1; k < 8; k++) begin
      step();
      chk_out("rr", fair_exp[k], 3'd4);
    end
    in_valid = '0;
    step();
    chk("rr_drain_valid", 32'(out_if.valid), 32'h0);
    chk("rr_ret",         32'(retired_cnt),  32'h8);

    // vector instruction on unit 2 stays atomic against unit 0
    in_vec[2]  = 1'b1;
    in_last[2] = 1'b0;
    in_valid   = 4'b0100;
    step();
    chk_out("vec0", 16'h22, 3'd4);
    in_valid = 4'b0101;
    half();
    chk("lock_rdy0", 32'(in_ready[0]), 32'h0);
    edge_t();
    chk_out("vec1", 16'h23, 3'd4);
    in_valid = 4'b0001;
    half();
    chk("lock_gap_rdy0", 32'(in_ready[0]), 32'h0);
    chk("lock_gap_rdy2", 32'(in_ready[2]), 32'h1);
    edge_t();
    chk("lock_gap_valid", 32'(out_if.valid), 32'h0);
    chk("lock_gap_ret",   32'(retired_cnt),  32'h8);
    in_valid   = 4'b0101;
    in_last[2] = 1'b1;
    step();
    chk_out("vec2", 16'h24, 3'd4);
    in_valid   = 4'b0001;
    in_vec[2]  = 1'b0;
    in_last[2] = 1'b0;
    step();
    chk_out("after_vec", 16'h02, 3'd4);
    chk("vec_ret", 32'(retired_cnt), 32'h9);
    in_valid = '0;
    step();
    chk("vec_drain_ret", 32'(retired_cnt), 32'hA);

    // backpressure with units 1 and 3
    out_ready = 1'b0;
    in_valid  = 4'b1010;
    step();
    chk_out("bp_load", 16'h12, 3'd4);
    in_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      half();
      chk("bp_rdy", 32'(in_ready), 32'h0);
      edge_t();
      chk_out("bp_hold", 16'h12, 3'd4);
    end
    out_ready = 1'b1;
    half();
    chk("bp_rel_rdy", 32'(in_ready), 32'h8);
    edge_t();
    chk_out("bp_next", 16'h32, 3'd4);
    chk("bp_ret1", 32'(retired_cnt), 32'hB);
    in_valid = '0;
    step();
    chk("bp_drain_valid", 32'(out_if.valid), 32'h0);
    chk("bp_ret2",        32'(retired_cnt),  32'hC);

    // thread count follows tmask popcount
    in_valid    = 4'b0001;
    in_tmask[0] = 4'hF;
    step();
    chk_out("tc_f", 16'h03, 3'd4);
    in_tmask[0] = 4'h5;
    step();
    chk_out("tc_5", 16'h04, 3'd2);
    chk("tc_5_tmask", 32'(out_if.tmask), 32'h5);
    in_tmask[0] = 4'h0;
    step();
    chk_out("tc_0", 16'h05, 3'd0);
    in_valid = '0;
    step();
    chk("tc_ret", 32'(retired_cnt), 32'hF);

    // two more retirements: 17 total wraps a 4-bit counter to 1
    in_tmask[0] = 4'hF;
    in_valid    = 4'b0010;
    step();
    chk_out("wrap0", 16'h13, 3'd4);
    step();
    chk_out("wrap1", 16'h14, 3'd4);
    chk("wrap_mid_ret", 32'(retired_cnt), 32'h0);
    in_valid = '0;
    step();
    chk("wrap_ret", 32'(retired_cnt), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vx_commit_arbiter.md
# VX_commit_arbiter

Per-issue-slot commit arbiter that sits directly downstream of the commit gather stage. Each execution unit (ALU, LSU, SFU, VPU) delivers one already-gathered commit stream for a given issue slot. This block merges those streams into the single commit port that feeds writeback and the scoreboard release. It uses fair round-robin arbitration, keeps multi-packet instructions atomic, registers the output, and keeps a retired-instruction counter for performance monitoring.

## Interface
- NUM_EX_UNITS, default 4: number of execution-unit commit streams merged.
- NUM_LANES, default `NUM_THREADS: lanes per commit packet, which are full warp width after gather.
- CNT_W, default 32: retired-instruction counter width.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- commit_in_if[NUM_EX_UNITS]  VX_commit_if.slave  -  per-unit commit streams, carrying uuid, wid, tmask, PC, wb, rd, data, pid, sop, eop, and with EXT_V_ENABLE also is_vec, vd, vd_lane_id, vd_is_last.
- commit_out_if  VX_commit_if.master  -  merged commit stream to writeback/scoreboard.
- commit_tcnt  out  `CLOG2(NUM_LANES+1)  popcount of commit_out_if.data.tmask, aligned with commit_out_if.valid.
- retired_cnt  out  CNT_W  number of instructions retired since reset.

## Operation
- Grant selection:
  - Round-robin over the inputs whose valid is asserted, starting at pointer `rr_ptr`.
  - The grant is the first valid index at or after `rr_ptr`, modulo NUM_EX_UNITS.
- Transfer condition: an input packet is accepted when `valid && grant && ready_in`.
  - `ready_in = !out_valid_q || commit_out_if.ready`.
  - All non-granted inputs see ready=0.
- Packet-end condition: `pkt_end = eop`. With EXT_V_ENABLE and is_vec=1, `pkt_end = eop && vd_is_last`.
- Lock behaviour:
  - Accepting a packet with pkt_end=0 sets `lock=1` and `lock_idx=grant`.
  - While locked, the grant is forced to lock_idx, even if that input is invalid; the other inputs stall.
  - Accepting a packet with pkt_end=1 from lock_idx clears the lock.
- Pointer update: on every accepted packet with pkt_end=1, `rr_ptr <= grant+1`, wrapping NUM_EX_UNITS-1 to 0. The pointer does not move mid-packet.
- Output register:
  - On accept, data is copied verbatim into the output register and out_valid_q is set.
  - When `commit_out_if.ready` is high and nothing is accepted, out_valid_q is cleared.
  - commit_tcnt is computed on accept and registered alongside the data.
- retired_cnt increments by 1 on each output handshake (`commit_out_if.valid && ready`) where the output pkt_end=1. It wraps modulo 2^CNT_W.
- NUM_EX_UNITS=1 degenerates as follows: the grant is always 0, the lock is still tracked, and the output register is retained.

## Timing
- Latency: input accept to commit_out_if.valid is 1 cycle.
- Throughput: 1 packet/cycle when downstream ready is held high; there are no bubbles between back-to-back packets, including grant switches.
- The input ready path is combinational from commit_out_if.ready. There is no combinational valid→valid path.
- Reset, asynchronous, clears all of the following immediately:
  - commit_out_if.valid=0
  - out_valid_q=0
  - commit_tcnt=0
  - retired_cnt=0
  - rr_ptr=0
  - lock=0, lock_idx=0
  - The output data register is don't-care.
- Reset in the middle of a locked packet abandons the packet. After reset deassertion, arbitration restarts from index 0 with no lock.
- Output stall: while commit_out_if.valid=1 and ready=0, the output data is held stable, and every input ready is 0.
- Simultaneous output drain and new accept in the same cycle: the register is reloaded, valid stays 1, and retired_cnt counts the drained packet.
- Locked input invalid for N cycles: the output goes empty after draining, and other inputs wait N cycles. No timeout is applied.

## Test plan
- Reset / idle check:
  - Stimulus: reset asserted mid-cycle, all inputs valid.
  - Required response: outputs go to 0 asynchronously. First accept after release is index 0, and commit_out_if.valid rises exactly 1 cycle later.
- Round-robin fairness:
  - Stimulus: all 4 inputs hold single-packet streams (eop=1) for 8 cycles, downstream ready=1.
  - Required response: output order is units 0,1,2,3,0,1,2,3, and retired_cnt=8.
- Atomic multi-packet (vector):
  - Stimulus: unit 2 sends a 3-packet vector instruction (vd_is_last only on packet 3, eop=1 on all); unit 0 is continuously valid.
  - Required response: the output shows the three unit-2 packets back-to-back, then unit 0. retired_cnt increments only once for unit 2.
- Backpressure:
  - Stimulus: downstream ready=0 for 5 cycles with units 1 and 3 valid.
  - Required response: output data is stable and the input readies are 0 for those cycles. After release the drain order is 1 then 3, with no loss or duplication.
- Thread count:
  - Stimulus: packets with tmask 0xF, 0x5, 0x0 (NUM_LANES=4).
  - Required response: commit_tcnt is 4, 2, 0, aligned with each output valid.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 retirements.
  - Required response: retired_cnt reads 1.
